// File: rtl/hilo_mdu_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package hilo_mdu_pkg;

  localparam int unsigned MduOpWd  = 5;
  // One-hot op vector bit positions: {mul, mult, multu, div, divu}
  localparam int unsigned OpMul    = 4;
  localparam int unsigned OpMult   = 3;
  localparam int unsigned OpMultu  = 2;
  localparam int unsigned OpDiv    = 1;
  localparam int unsigned OpDivu   = 0;

  localparam int unsigned DivIter  = 32;
  localparam int unsigned DivCntWd = $clog2(DivIter);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_div_core.sv
// Unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle.
module hilo_mdu_div_core
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy
);

  logic [31:0]         rem_q, quo_q, dvs_q;
  logic [DivCntWd-1:0] cnt_q;
  logic                active_q;

  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] step_rem, step_quo;

  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign ge       = ~diff[32];
  assign step_rem = ge ? diff[31:0] : shifted[31:0];
  assign step_quo = {quo_q[30:0], ge};

  // Results show the step retired this cycle, so the caller can capture the
  // final value on the same edge as the last iteration.
  assign quotient  = active_q ? step_quo : quo_q;
  assign remainder = active_q ? step_rem : rem_q;

  // Drops during the final iteration: the caller retires on the next edge.
  assign busy = active_q && (cnt_q != DivCntWd'(DivIter - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= cnt_q + DivCntWd'(1);
      if (cnt_q == DivCntWd'(DivIter - 1)) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle MULT/MULTU/MUL/DIV/DIVU sequencer feeding the HI/LO write bus.
module hilo_mdu
  import hilo_mdu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [MduOpWd-1:0] op,
  input  logic [31:0]        src1,
  input  logic [31:0]        src2,
  output logic               stall_req,
  output logic               done,
  output logic               hi_we,
  output logic               lo_we,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o,
  output logic [31:0]        mul_result
);

  mdu_state_e  state;
  logic        sgn_q, rd_q;
  logic [31:0] src1_q, src2_q;
  logic        done_q, hi_we_q, lo_we_q;
  logic [31:0] hi_q, lo_q, mr_q;

  logic        is_mul, is_div, op_sgn, accept, div_load, div_busy;
  logic [31:0] dividend_mag, divisor_mag, div_quo, div_rem;
  logic [32:0] mul_a, mul_b;
  logic [63:0] prod;

  assign is_mul = op[OpMul] | op[OpMult] | op[OpMultu];
  assign is_div = op[OpDiv] | op[OpDivu];
  assign op_sgn = op[OpMul] | op[OpMult] | op[OpDiv];
  assign accept = (state == StIdle) && start && !flush && (is_mul || is_div);

  assign div_load     = accept && is_div && (src2 != '0);
  assign dividend_mag = neg_if(op[OpDiv] & src1[31], src1);
  assign divisor_mag  = neg_if(op[OpDiv] & src2[31], src2);

  // 33-bit extension makes one signed multiply serve both signednesses.
  assign mul_a = {sgn_q & src1_q[31], src1_q};
  assign mul_b = {sgn_q & src2_q[31], src2_q};
  assign prod  = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  assign stall_req  = !flush && (accept || (state == StMul) || (state == StDiv));
  assign done       = done_q & ~flush;
  assign hi_we      = hi_we_q & ~flush;
  assign lo_we      = lo_we_q & ~flush;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign mul_result = mr_q;

  hilo_mdu_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (div_load),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .busy      (div_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      sgn_q   <= 1'b0;
      rd_q    <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      done_q  <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mr_q    <= '0;
    end else if (flush) begin
      state   <= StIdle;
      done_q  <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mr_q    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            sgn_q  <= op_sgn;
            rd_q   <= op[OpMul];
            src1_q <= src1;
            src2_q <= src2;
            if (is_mul) begin
              state <= StMul;
            end else if (src2 == '0) begin
              state   <= StDone;
              done_q  <= 1'b1;
              hi_we_q <= 1'b1;
              lo_we_q <= 1'b1;
              hi_q    <= src1;
              lo_q    <= '1;
            end else begin
              state <= StDiv;
            end
          end
        end
        StMul: begin
          state  <= StDone;
          done_q <= 1'b1;
          if (rd_q) begin
            mr_q <= prod[31:0];
          end else begin
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
          end
        end
        StDiv: begin
          if (!div_busy) begin
            state   <= StDone;
            done_q  <= 1'b1;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
            // Quotient negated on sign mismatch; remainder follows dividend.
            lo_q    <= neg_if(sgn_q & (src1_q[31] ^ src2_q[31]), div_quo);
            hi_q    <= neg_if(sgn_q & src1_q[31], div_rem);
          end
        end
        StDone: begin
          state   <= StIdle;
          done_q  <= 1'b0;
          hi_we_q <= 1'b0;
          lo_we_q <= 1'b0;
          hi_q    <= '0;
          lo_q    <= '0;
          mr_q    <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomised and directed bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;

  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_DIV   = 5'b00010;
  localparam logic [4:0] OP_DIVU  = 5'b00001;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mr;
    logic        stall_at_done;
  } res_t;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] a, b, hi, lo, mr;
    logic        we;
    int          lat;
  } vec_t;

  logic        clk, rst, flush, start;
  logic [4:0]  op;
  logic [31:0] src1, src2;
  logic        stall_req, done, hi_we, lo_we;
  logic [31:0] hi_o, lo_o, mul_result;

  int checks = 0;
  int errors = 0;

  hilo_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .start      (start),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .stall_req  (stall_req),
    .done       (done),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic res_t model(input logic [4:0] o, input logic [31:0] a, b, output int lat);
    res_t        r;
    logic [63:0] p;
    longint      sa, sb;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == OP_MUL || o == OP_MULT || o == OP_MULTU) begin
      lat = 2;
      if (o == OP_MULTU) p = {32'd0, a} * {32'd0, b};
      else p = sa * sb;
      if (o == OP_MUL) r.mr = p[31:0];
      else begin
        r.hi = p[63:32]; r.lo = p[31:0]; r.hi_we = 1'b1; r.lo_we = 1'b1;
      end
    end else begin
      r.hi_we = 1'b1; r.lo_we = 1'b1;
      if (b == 32'd0) begin
        lat = 1; r.hi = a; r.lo = 32'hFFFF_FFFF;
      end else begin
        lat = 33;
        if (o == OP_DIVU) begin
          r.lo = a / b; r.hi = a % b;
        end else begin
          p = sa / sb; r.lo = p[31:0];
          p = sa % sb; r.hi = p[31:0];
        end
      end
    end
    return r;
  endfunction

  // Issue one op at the current cycle, hold start until done, return observations.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, b,
                        output res_t r, output int lat, output int stalls);
    r = '0; lat = -1; stalls = 0;
    op = o; src1 = a; src2 = b; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (done) begin
        lat = c;
        r.hi_we = hi_we; r.lo_we = lo_we;
        if (o == OP_MUL) r.mr = mul_result;
        else begin r.hi = hi_o; r.lo = lo_o; end
        r.stall_at_done = stall_req;
        break;
      end
      if (stall_req) stalls++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_req, done, hi_we, lo_we, hi_o, lo_o, mul_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%h/%h want all zero",
               {stall_req, done, hi_we, lo_we}, hi_o, lo_o, mul_result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t v[8];
    res_t obs, exp_r;
    int   lat, stalls;
    v[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h0, 1'b1, 2};
    v[1] = '{OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0, 1'b1, 2};
    v[2] = '{OP_MUL, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'hFFFF_FFFA, 1'b0, 2};
    v[3] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 1'b1, 33};
    v[4] = '{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32'h0, 1'b1, 33};
    v[5] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 33};
    v[6] = '{OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1};
    v[7] = '{OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0, 1'b1, 1};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].o, v[i].a, v[i].b, obs, lat, stalls);
      exp_r = '{hi_we: v[i].we, lo_we: v[i].we, hi: v[i].hi, lo: v[i].lo, mr: v[i].mr,
                stall_at_done: 1'b0};
      checks++;
      if (obs !== exp_r) begin
        errors++;
        $display("FAIL directed_%0d result got %h want %h", i, obs, exp_r);
      end
      checks++;
      if (lat !== v[i].lat || stalls !== v[i].lat) begin
        errors++;
        $display("FAIL directed_%0d timing got lat %0d stalls %0d want %0d", i, lat, stalls,
                 v[i].lat);
      end
    end
  endtask

  task automatic test_flush();
    res_t obs, exp_r;
    int   lat, stalls, exp_lat, pulses;
    op = OP_DIVU; src1 = 32'hDEAD_BEEF; src2 = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if ({stall_req, done, hi_we, lo_we} !== 4'b0) begin
      errors++;
      $display("FAIL flush_mid_div got stall/done/we %b want 0000",
               {stall_req, done, hi_we, lo_we});
    end
    @(posedge clk); #1;
    flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || hi_we || lo_we || stall_req) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_no_escape got %0d active cycles want 0", pulses);
    end
    // Flush coincident with start must not accept the op.
    op = OP_MULT; src1 = 32'd6; src2 = 32'd7; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done || stall_req) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_with_start got %0d active cycles want 0", pulses);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, obs, lat, stalls);
    exp_r = model(OP_DIVU, 32'd9, 32'd3, exp_lat);
    checks++;
    if (obs !== exp_r || lat !== exp_lat) begin
      errors++;
      $display("FAIL after_flush_divu got %h lat %0d want %h lat %0d", obs, lat, exp_r, exp_lat);
    end
  endtask

  task automatic test_rst_mid();
    res_t obs, exp_r;
    int   lat, stalls, exp_lat, pulses;
    op = OP_MULT; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done, hi_we, lo_we, hi_o, lo_o, mul_result} !== '0) begin
      errors++;
      $display("FAIL rst_in_mul got %b/%h/%h/%h want all zero",
               {done, hi_we, lo_we}, hi_o, lo_o, mul_result);
    end
    rst = 1'b0; flush = 1'b0;
    op = OP_DIV; src1 = 32'hFFFF_0000; src2 = 32'd5; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || hi_we || lo_we || stall_req || hi_o != 0 || lo_o != 0) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_in_div got %0d active cycles want 0", pulses);
    end
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, obs, lat, stalls);
    exp_r = model(OP_DIV, 32'hFFFF_FF9C, 32'd7, exp_lat);
    checks++;
    if (obs !== exp_r || lat !== exp_lat) begin
      errors++;
      $display("FAIL after_rst_div got %h lat %0d want %h lat %0d", obs, lat, exp_r, exp_lat);
    end
  endtask

  task automatic test_start_held();
    int pulses;
    bit seen;
    pulses = 0; seen = 1'b0;
    op = OP_MULT; src1 = 32'hFFFF_FFFE; src2 = 32'd3; start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (done) begin pulses++; seen = 1'b1; end
      @(posedge clk); #1;
      if (seen) start = 1'b0;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL start_held_done_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    res_t        obs, exp_r;
    int          lat, stalls, exp_lat;
    logic [4:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 5'd1 << $urandom_range(0, 4);
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      run_op(o, a, b, obs, lat, stalls);
      exp_r = model(o, a, b, exp_lat);
      checks++;
      if (obs !== exp_r) begin
        errors++;
        $display("FAIL random_%0d op %b a %h b %h got %h want %h", i, o, a, b, obs, exp_r);
      end
      checks++;
      if (lat !== exp_lat || stalls !== exp_lat) begin
        errors++;
        $display("FAIL random_%0d timing got lat %0d stalls %0d want %0d", i, lat, stalls,
                 exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_rst_mid();
    test_start_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
